atmega_eep_bridge: RTL and testbench

Host-side save/load engine for the ATmega EEPROM peripheral. It drives the peripheral's external access port (address, data, wr, rd, en). It streams the full EEPROM image to the host as 32-bit little-endian words (dump), or writes a host word stream into the EEPROM (load). It sits between the platform's data-slot/bridge logic and the EEPROM block, and holds the CPU off while active.

---
 rtl/atmega_eep_bridge_if.sv | 37 +++
 rtl/atmega_eep_bridge.sv | 157 +++++++++++++++
 tb/tb_atmega_eep_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/atmega_eep_bridge_if.sv
// Host/EEPROM-side bundle for atmega_eep_bridge: request/status, the two word
// streams, and the peripheral's external access port.
interface atmega_eep_bridge_if #(
  parameter int ADDR_W = 17
);
  logic              dump_req;
  logic              load_req;
  logic              busy;
  logic              done;
  logic              cpu_hold;
  logic [31:0]       rd_word;
  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       wr_word;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] eep_addr;
  logic [7:0]        eep_wdata;
  logic              eep_wr;
  logic              eep_rd;
  logic              eep_en;
  logic [7:0]        eep_rdata;

  // Bridge side
  modport slave (
    input  dump_req, load_req, rd_ready, wr_word, wr_valid, eep_rdata,
    output busy, done, cpu_hold, rd_word, rd_valid, wr_ready,
           eep_addr, eep_wdata, eep_wr, eep_rd, eep_en
  );

  // Host / peripheral side
  modport master (
    output dump_req, load_req, rd_ready, wr_word, wr_valid, eep_rdata,
    input  busy, done, cpu_hold, rd_word, rd_valid, wr_ready,
           eep_addr, eep_wdata, eep_wr, eep_rd, eep_en
  );
endinterface

// File: rtl/atmega_eep_bridge.sv
// Save/load engine for the ATmega EEPROM: dumps the whole image as 32-bit
// little-endian words, or writes a host word stream back byte by byte.
module atmega_eep_bridge #(
  parameter int EEP_SIZE = 1024,
  parameter int ADDR_W   = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  atmega_eep_bridge_if.slave    bus
);
  localparam int CW = $clog2(EEP_SIZE) + 1;

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_CAP, RD_PUSH, WR_POP, WR_BYTE, DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [7:0]      rd_lane_reg [4];
  logic [7:0]      wr_lane_reg [4];
  logic [1:0]      lane;
  logic            last_byte;

  logic              busy, done, rd_valid, wr_ready;
  logic              eep_wr, eep_rd, eep_en;
  logic [ADDR_W-1:0] eep_addr;
  logic [7:0]        eep_wdata;

  assign lane      = cnt_reg[1:0];
  assign last_byte = (cnt_reg + CW'(1)) == CW'(EEP_SIZE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Per-lane byte storage: read lanes fill one per RD_CAP, write lanes load a whole word
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_lane_reg[gi] <= '0;
        end else if (state_reg == RD_CAP && lane == 2'(gi)) begin
          rd_lane_reg[gi] <= bus.eep_rdata;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_lane_reg[gi] <= '0;
        end else if (state_reg == WR_POP && bus.wr_valid) begin
          wr_lane_reg[gi] <= bus.wr_word[8*gi +: 8];
        end
      end

      assign bus.rd_word[8*gi +: 8] = rd_lane_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy       = 1'b0;
    done       = 1'b0;
    rd_valid   = 1'b0;
    wr_ready   = 1'b0;
    eep_wr     = 1'b0;
    eep_rd     = 1'b0;
    eep_en     = 1'b0;
    eep_addr   = '0;
    eep_wdata  = '0;

    case (state_reg)
      IDLE: begin
        if (bus.dump_req) begin
          state_next = RD_ADDR;
          cnt_next   = '0;
        end else if (bus.load_req) begin
          state_next = WR_POP;
          cnt_next   = '0;
        end
      end

      RD_ADDR: begin
        busy       = 1'b1;
        eep_en     = 1'b1;
        eep_rd     = 1'b1;
        eep_addr   = ADDR_W'(cnt_reg);
        state_next = RD_CAP;
      end

      // Peripheral data for the address presented last cycle is valid now
      RD_CAP: begin
        busy       = 1'b1;
        eep_en     = 1'b1;
        eep_rd     = 1'b1;
        eep_addr   = ADDR_W'(cnt_reg);
        cnt_next   = cnt_reg + CW'(1);
        state_next = (lane == 2'd3) ? RD_PUSH : RD_ADDR;
      end

      RD_PUSH: begin
        busy     = 1'b1;
        eep_en   = 1'b1;
        rd_valid = 1'b1;
        if (bus.rd_ready) begin
          state_next = (cnt_reg == CW'(EEP_SIZE)) ? DONE : RD_ADDR;
        end
      end

      WR_POP: begin
        busy     = 1'b1;
        eep_en   = 1'b1;
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          state_next = WR_BYTE;
        end
      end

      WR_BYTE: begin
        busy      = 1'b1;
        eep_en    = 1'b1;
        eep_wr    = 1'b1;
        eep_addr  = ADDR_W'(cnt_reg);
        eep_wdata = wr_lane_reg[lane];
        cnt_next  = cnt_reg + CW'(1);
        if (lane == 2'd3) begin
          state_next = last_byte ? DONE : WR_POP;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy      = busy;
  assign bus.cpu_hold  = busy;
  assign bus.done      = done;
  assign bus.rd_valid  = rd_valid;
  assign bus.wr_ready  = wr_ready;
  assign bus.eep_wr    = eep_wr;
  assign bus.eep_rd    = eep_rd;
  assign bus.eep_en    = eep_en;
  assign bus.eep_addr  = eep_addr;
  assign bus.eep_wdata = eep_wdata;
endmodule

// File: tb/tb_atmega_eep_bridge.sv
// Directed bench for atmega_eep_bridge with a registered-read EEPROM model;
// one line per transaction and a single summary line.
module tb_atmega_eep_bridge;
  localparam int EEP_SIZE = 1024;
  localparam int ADDR_W   = 17;
  localparam int AW       = $clog2(EEP_SIZE);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  atmega_eep_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  atmega_eep_bridge #(.EEP_SIZE(EEP_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // EEPROM model: read registered on the address edge, write on the strobe edge
  logic [7:0] mem [EEP_SIZE];
  always @(posedge clk) begin
    if (bus.eep_en && bus.eep_rd) bus.eep_rdata <= mem[bus.eep_addr[AW-1:0]];
    if (bus.eep_en && bus.eep_wr) mem[bus.eep_addr[AW-1:0]] <= bus.eep_wdata;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0]       rd_q [$];
  logic [ADDR_W-1:0] wa_q [$];
  logic [7:0]        wd_q [$];
  int done_cnt, done_cyc, busy_cyc, bad_wr_pop, bad_both, bad_hold, req_cyc;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.rd_valid && bus.rd_ready) rd_q.push_back(bus.rd_word);
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.busy) busy_cyc++;
      if (bus.eep_wr) begin wa_q.push_back(bus.eep_addr); wd_q.push_back(bus.eep_wdata); end
      if (bus.eep_wr && bus.wr_ready) bad_wr_pop++;
      if (bus.eep_wr && bus.eep_rd) bad_both++;
      if (bus.cpu_hold != bus.busy) bad_hold++;
    end
  end

  function automatic logic [7:0] ctl_outs();
    return {bus.busy, bus.done, bus.cpu_hold, bus.rd_valid,
            bus.wr_ready, bus.eep_wr, bus.eep_rd, bus.eep_en};
  endfunction

  function automatic logic [31:0] dump_exp(input int k);
    return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
  endfunction

  function automatic logic [7:0] load_exp(input int j);
    logic [31:0] w;
    w = 32'hA5A5A5A5 + 32'(j / 4);
    return w[8*(j%4) +: 8];
  endfunction

  task automatic clear_mon();
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    done_cnt = 0; busy_cyc = 0; bad_wr_pop = 0; bad_both = 0; bad_hold = 0;
  endtask

  // Called at posedge+1; the request is sampled at the next edge
  task automatic pulse(input logic d, input logic l);
    bus.dump_req = d;
    bus.load_req = l;
    @(negedge clk);
    req_cyc = cyc;
    @(posedge clk); #1;
    bus.dump_req = 1'b0;
    bus.load_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin @(posedge clk); n++; end
    #1;
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    $display("%s: done after %0d cycles, busy %0d cycles", tag, done_cyc - req_cyc, busy_cyc);
  endtask

  task automatic check_dump(input string tag);
    int nerr = 0;
    int sz;
    sz = rd_q.size();
    check({tag, "_words"}, 32'(sz), 32'd256);
    for (int k = 0; k < sz && k < 256; k++) if (rd_q[k] !== dump_exp(k)) nerr++;
    check({tag, "_word_errs"}, 32'(nerr), 32'd0);
    check({tag, "_first"}, (sz > 0) ? rd_q[0] : 32'hDEADBEEF, 32'h03020100);
    check({tag, "_last"}, (sz > 0) ? rd_q[sz-1] : 32'hDEADBEEF, 32'hFFFEFDFC);
    check({tag, "_no_writes"}, 32'(wa_q.size()), 32'd0);
    check({tag, "_hold"}, 32'(bad_hold), 32'd0);
  endtask

  task automatic check_load(input string tag);
    int nerr = 0;
    int sz;
    sz = wa_q.size();
    check({tag, "_bytes"}, 32'(sz), 32'd1024);
    for (int j = 0; j < sz && j < 1024; j++)
      if (wa_q[j] !== ADDR_W'(j) || wd_q[j] !== load_exp(j)) nerr++;
    check({tag, "_byte_errs"}, 32'(nerr), 32'd0);
    check({tag, "_mem4"}, 32'(mem[4]), 32'hA6);
    check({tag, "_mem7"}, 32'(mem[7]), 32'hA5);
    check({tag, "_wr_in_pop"}, 32'(bad_wr_pop), 32'd0);
    check({tag, "_wr_rd"}, 32'(bad_both), 32'd0);
  endtask

  // gap: cycles wr_valid is dropped after each accepted word
  task automatic do_load(input string tag, input int gap);
    int i = 0;
    int n = 0;
    bus.wr_word  = 32'hA5A5A5A5;
    bus.wr_valid = 1'b1;
    pulse(1'b0, 1'b1);
    while (i < 256 && n < 5000) begin
      @(negedge clk);
      n++;
      if (bus.wr_valid && bus.wr_ready) begin
        @(posedge clk); #1;
        i++;
        bus.wr_word = 32'hA5A5A5A5 + 32'(i);
        if (gap > 0) begin
          bus.wr_valid = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
          bus.wr_valid = 1'b1;
        end
      end
    end
    bus.wr_valid = 1'b0;
    check({tag, "_words_fed"}, 32'(i), 32'd256);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    bus.dump_req = 1'b0;
    bus.load_req = 1'b0;
    bus.rd_ready = 1'b1;
    bus.wr_word  = '0;
    bus.wr_valid = 1'b0;
    for (int i = 0; i < EEP_SIZE; i++) mem[i] = 8'(i);

    // Reset state
    #2;
    check("rst_ctl", 32'(ctl_outs()), 32'd0);
    check("rst_addr", 32'(bus.eep_addr), 32'd0);
    check("rst_rd_word", bus.rd_word, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset mid-dump
    clear_mon();
    pulse(1'b1, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_ctl", 32'(ctl_outs()), 32'd0);
    check("mid_rst_addr", 32'(bus.eep_addr), 32'd0);
    check("mid_rst_wdata", 32'(bus.eep_wdata), 32'd0);
    check("mid_rst_rd_word", bus.rd_word, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    $display("reset mid-dump: outputs 0x%02h", ctl_outs());

    // Full dump, rd_ready held high
    clear_mon();
    pulse(1'b1, 1'b0);
    check("dump_restart_addr", 32'(bus.eep_addr), 32'd0);
    check("dump_restart_rd", 32'(bus.eep_rd), 32'd1);
    wait_done("dump", 3000);
    check("dump_latency", 32'(done_cyc - req_cyc), 32'd2305);
    check_dump("dump");

    // Dump with a 10-cycle stall on word 2
    clear_mon();
    pulse(1'b1, 1'b0);
    n = 0;
    while (rd_q.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    bus.rd_ready = 1'b0;
    n = 0;
    while (!bus.rd_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("stall_reached", 32'(bus.rd_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.rd_valid), 32'd1);
      check("stall_word", bus.rd_word, 32'h0B0A0908);
      check("stall_eep_rd", 32'(bus.eep_rd), 32'd0);
      @(posedge clk); #1;
    end
    bus.rd_ready = 1'b1;
    wait_done("dump_bp", 3000);
    check_dump("dump_bp");

    // Simultaneous requests, then load_req mid-dump
    clear_mon();
    pulse(1'b1, 1'b1);
    check("both_req_is_dump", 32'({bus.eep_rd, bus.wr_ready}), 32'b10);
    repeat (50) @(posedge clk);
    #1;
    pulse(1'b0, 1'b1);
    check("load_ignored", 32'(bus.wr_ready), 32'd0);
    wait_done("dump_both", 3000);
    check_dump("dump_both");

    // Gapless load
    clear_mon();
    do_load("load", 0);
    wait_done("load", 2000);
    check("load_busy_cycles", 32'(busy_cyc), 32'd1280);
    check_load("load");

    // Load with wr_valid gaps long enough to leave WR_POP waiting
    for (int i = 0; i < EEP_SIZE; i++) mem[i] = 8'h00;
    clear_mon();
    do_load("load_gap", 7);
    wait_done("load_gap", 5000);
    check_load("load_gap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
